// File: rtl/rsg_sequence_monitor.sv
// Receive-side checker for the ready/set/go command sequence (laps, errors, lock).
// Define RSG_MON_STRICT_EN to require every phase to last exactly one cycle.
module rsg_sequence_monitor #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             get_ready,
    input  logic             get_set,
    input  logic             get_going,
    input  logic             clr,
    output logic             in_sync,
    output logic             lap_done,
    output logic             seq_err,
    output logic             resync,
    output logic [CNT_W-1:0] lap_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        IN_READY   = 2'd1,
        IN_SET     = 2'd2,
        IN_GO      = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        C_ZERO  = 3'd0,
        C_R     = 3'd1,
        C_S     = 3'd2,
        C_G     = 3'd3,
        C_MULTI = 3'd4
    } code_t;

    state_t           r_state;
    state_t           w_next_state;
    code_t            w_code;
    logic             w_lap;
    logic             w_err;
    logic             w_resync;
    logic             r_lap_done;
    logic             r_seq_err;
    logic             r_resync;
    logic [CNT_W-1:0] r_lap_count;
    logic [CNT_W-1:0] r_err_count;
    logic [1:0]       w_ones;

    assign w_ones = 2'(get_ready) + 2'(get_set) + 2'(get_going);

    always_comb begin
        w_code = C_ZERO;
        if (w_ones > 2'd1) begin
            w_code = C_MULTI;
        end else begin
            unique case (1'b1)
                get_ready: w_code = C_R;
                get_set:   w_code = C_S;
                get_going: w_code = C_G;
                default:   w_code = C_ZERO;
            endcase
        end
    end

    // A hold sample keeps the phase unless strict one-cycle phasing is required.
    always_comb begin
        w_next_state = r_state;
        w_lap        = 1'b0;
        w_err        = 1'b0;
        w_resync     = 1'b0;
        unique case (r_state)
            WAIT_READY: begin
                unique case (w_code)
                    C_ZERO:  w_next_state = WAIT_READY;
                    C_R:     w_next_state = IN_READY;
                    default: w_err = 1'b1;
                endcase
            end
            IN_READY: begin
                unique case (w_code)
                    C_S: w_next_state = IN_SET;
                    C_R: begin
`ifdef RSG_MON_STRICT_EN
                        w_next_state = WAIT_READY;
                        w_err        = 1'b1;
`else
                        w_next_state = IN_READY;
`endif
                    end
                    C_ZERO: begin
                        w_next_state = WAIT_READY;
                        w_resync     = 1'b1;
                    end
                    default: begin
                        w_next_state = WAIT_READY;
                        w_err        = 1'b1;
                    end
                endcase
            end
            IN_SET: begin
                unique case (w_code)
                    C_G: begin
                        w_next_state = IN_GO;
                        w_lap        = 1'b1;
                    end
                    C_S: begin
`ifdef RSG_MON_STRICT_EN
                        w_next_state = WAIT_READY;
                        w_err        = 1'b1;
`else
                        w_next_state = IN_SET;
`endif
                    end
                    C_ZERO: begin
                        w_next_state = WAIT_READY;
                        w_resync     = 1'b1;
                    end
                    default: begin
                        w_next_state = WAIT_READY;
                        w_err        = 1'b1;
                    end
                endcase
            end
            IN_GO: begin
                unique case (w_code)
                    C_R: w_next_state = IN_READY;
                    C_G: begin
`ifdef RSG_MON_STRICT_EN
                        w_next_state = WAIT_READY;
                        w_err        = 1'b1;
`else
                        w_next_state = IN_GO;
`endif
                    end
                    C_ZERO: begin
                        w_next_state = WAIT_READY;
                        w_resync     = 1'b1;
                    end
                    default: begin
                        w_next_state = WAIT_READY;
                        w_err        = 1'b1;
                    end
                endcase
            end
            default: w_next_state = WAIT_READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= WAIT_READY;
            r_lap_done <= 1'b0;
            r_seq_err  <= 1'b0;
            r_resync   <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_lap_done <= w_lap;
            r_seq_err  <= w_err;
            r_resync   <= w_resync;
        end
    end

    // Clear beats a same-cycle increment; the error counter saturates.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            r_lap_count <= '0;
            r_err_count <= '0;
        end else begin
            if (w_lap) begin
                r_lap_count <= r_lap_count + CNT_W'(1);
            end
            if (w_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
        end
    end

    assign in_sync   = (r_state != WAIT_READY);
    assign lap_done  = r_lap_done;
    assign seq_err   = r_seq_err;
    assign resync    = r_resync;
    assign lap_count = r_lap_count;
    assign err_count = r_err_count;

endmodule

// File: tb/tb_rsg_sequence_monitor.sv
// Directed scoreboard bench for rsg_sequence_monitor with a 2-bit counter build.
module tb_rsg_sequence_monitor;

    localparam int W = 2;

    typedef struct {
        logic         sync;
        logic         lap;
        logic         err;
        logic         rsy;
        logic [W-1:0] lc;
        logic [W-1:0] ec;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         get_ready = 1'b0;
    logic         get_set = 1'b0;
    logic         get_going = 1'b0;
    logic         clr = 1'b0;
    logic         in_sync;
    logic         lap_done;
    logic         seq_err;
    logic         resync;
    logic [W-1:0] lap_count;
    logic [W-1:0] err_count;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    rsg_sequence_monitor #(.CNT_W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .get_ready (get_ready),
        .get_set   (get_set),
        .get_going (get_going),
        .clr       (clr),
        .in_sync   (in_sync),
        .lap_done  (lap_done),
        .seq_err   (seq_err),
        .resync    (resync),
        .lap_count (lap_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs,
                       input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // in: {ready,set,go}; ctl: {rst,clr}; expected outputs after the edge
    task automatic step(input string tag, input logic [2:0] in,
                        input logic [1:0] ctl, input logic s, input logic l,
                        input logic e, input logic r, input int lc,
                        input int ec);
        exp_t x;
        {get_ready, get_set, get_going} = in;
        {rst, clr} = ctl;
        x.sync = s; x.lap = l; x.err = e; x.rsy = r;
        x.lc = W'(lc); x.ec = W'(ec);
        sb_q.push_back(x);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: scoreboard empty", tag);
        end else begin
            x = sb_q.pop_front();
            chk({tag, ".in_sync"}, W'(in_sync), W'(x.sync));
            chk({tag, ".lap_done"}, W'(lap_done), W'(x.lap));
            chk({tag, ".seq_err"}, W'(seq_err), W'(x.err));
            chk({tag, ".resync"}, W'(resync), W'(x.rsy));
            chk({tag, ".lap_count"}, lap_count, x.lc);
            chk({tag, ".err_count"}, err_count, x.ec);
        end
    endtask

    localparam logic [2:0] Z = 3'b000;
    localparam logic [2:0] R = 3'b100;
    localparam logic [2:0] S = 3'b010;
    localparam logic [2:0] G = 3'b001;
    localparam logic [2:0] GR = 3'b101;
    localparam logic [1:0] N = 2'b00;
    localparam logic [1:0] C = 2'b01;
    localparam logic [1:0] X = 2'b10;

    initial begin
        #1;
        step("reset", Z, X, 0, 0, 0, 0, 0, 0);
        step("t1_zero", Z, N, 0, 0, 0, 0, 0, 0);
        step("t1_r", R, N, 1, 0, 0, 0, 0, 0);
        step("t1_s", S, N, 1, 0, 0, 0, 0, 0);
        step("t1_g", G, N, 1, 1, 0, 0, 1, 0);
        step("t1_r2", R, N, 1, 0, 0, 0, 1, 0);
        step("t1_s2", S, N, 1, 0, 0, 0, 1, 0);
        step("t1_g2", G, N, 1, 1, 0, 0, 2, 0);

        step("t2_r", R, N, 1, 0, 0, 0, 2, 0);
        step("t2_s", S, N, 1, 0, 0, 0, 2, 0);
        step("t2_multi", GR, N, 0, 0, 1, 0, 2, 1);
        step("t2_relock", R, N, 1, 0, 0, 0, 2, 1);

        step("t3_s", S, N, 1, 0, 0, 0, 2, 1);
        step("t3_z1", Z, N, 0, 0, 0, 1, 2, 1);
        step("t3_z2", Z, N, 0, 0, 0, 0, 2, 1);
        step("t3_z3", Z, N, 0, 0, 0, 0, 2, 1);
        step("t3_r", R, N, 1, 0, 0, 0, 2, 1);

        step("t4_clr", S, C, 1, 0, 0, 0, 0, 0);
        step("t4_lap1", G, N, 1, 1, 0, 0, 1, 0);
        for (int i = 0; i < 4; i++) begin
            step("t4_r", R, N, 1, 0, 0, 0, (1 + i) % 4, 0);
            step("t4_s", S, N, 1, 0, 0, 0, (1 + i) % 4, 0);
            step("t4_g", G, N, 1, 1, 0, 0, (2 + i) % 4, 0);
        end
        step("t4_zero", Z, N, 0, 0, 0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step("t4_err", S, N, 0, 0, 1, 0, 1, (i < 3) ? i + 1 : 3);
        end

        step("t5_clr_err", S, C, 0, 0, 1, 0, 0, 0);
        step("t5_r", R, N, 1, 0, 0, 0, 0, 0);
        step("t5_s", S, N, 1, 0, 0, 0, 0, 0);
        step("t5_g", G, N, 1, 1, 0, 0, 1, 0);
        step("t5_rst", R, 2'b11, 0, 0, 0, 0, 0, 0);
        step("t5_idle", Z, N, 0, 0, 0, 0, 0, 0);

`ifdef RSG_MON_STRICT_EN
        step("t6_r1", R, N, 1, 0, 0, 0, 0, 0);
        step("t6_r2", R, N, 0, 0, 1, 0, 0, 1);
        step("t6_r3", R, N, 1, 0, 0, 0, 0, 1);
        step("t6_s1", S, N, 1, 0, 0, 0, 0, 1);
        step("t6_s2", S, N, 0, 0, 1, 0, 0, 2);
        step("t6_r4", R, N, 1, 0, 0, 0, 0, 2);
        step("t6_s3", S, N, 1, 0, 0, 0, 0, 2);
        step("t6_g1", G, N, 1, 1, 0, 0, 1, 2);
        step("t6_g2", G, N, 0, 0, 1, 0, 1, 3);
`else
        step("t6_r1", R, N, 1, 0, 0, 0, 0, 0);
        step("t6_r2", R, N, 1, 0, 0, 0, 0, 0);
        step("t6_s1", S, N, 1, 0, 0, 0, 0, 0);
        step("t6_s2", S, N, 1, 0, 0, 0, 0, 0);
        step("t6_g1", G, N, 1, 1, 0, 0, 1, 0);
        step("t6_g2", G, N, 1, 0, 0, 0, 1, 0);
        step("t6_r3", R, N, 1, 0, 0, 0, 1, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
